// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector.
// Pattern length is 1..MAX_LEN bits, with overlap or non-overlap matching. It gives a
// Mealy match pulse, a registered copy of that pulse, and a saturating match counter.
module seq_detect_prog #(
  parameter int unsigned           MAX_LEN = 8,
  parameter int unsigned           LEN_W   = 4,
  parameter int unsigned           CNT_W   = 8,
  parameter logic [MAX_LEN-1:0]    DEF_PAT = 'h0D,
  parameter int unsigned           DEF_LEN = 4,
  parameter bit                    DEF_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  typedef enum logic {StRun, StErr} state_e;

  state_e               state_q;
  logic [MAX_LEN-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  // Prior accepted bits, newest at bit 0.
  logic [MAX_LEN-2:0]   hist_q;
  // Accepted-bit count, saturating at MAX_LEN.
  logic [LEN_W-1:0]     fill_q;

  logic [MAX_LEN-1:0]   window;
  logic [MAX_LEN-1:0]   mask;
  logic                 accept;
  logic                 fill_ok;
  logic                 match;
  logic                 len_valid;
  logic [LEN_W-1:0]     fill_inc;

  // Match decode: compare the low len bits of {hist, din} against the active pattern.
  always_comb begin
    window = {hist_q, din};
    mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(len_q) > i);
    end
    accept    = (state_q == StRun) && en && !cfg_load;
    fill_ok   = (32'(fill_q) + 32'd1) >= 32'(len_q);
    // rst_n gating keeps y low for the whole reset window.
    match     = rst_n && accept && fill_ok && (((window ^ pat_q) & mask) == '0);
    y         = match;
    cfg_err   = (state_q == StErr);
    len_valid = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
    fill_inc  = (32'(fill_q) >= MAX_LEN) ? fill_q : fill_q + 1'b1;
  end

  // Config/FSM, history, registered match and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pat_q     <= DEF_PAT;
      len_q     <= LEN_W'(DEF_LEN);
      ovl_q     <= DEF_OVL;
      hist_q    <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      y_q <= match;

      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end

      if (cfg_load) begin
        pat_q   <= cfg_pat;
        len_q   <= cfg_len;
        ovl_q   <= cfg_ovl;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= len_valid ? StRun : StErr;
      end else if (accept) begin
        if (match && !ovl_q) begin
          // Non-overlap: the next match must be built from len fresh bits.
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= window[MAX_LEN-2:0];
          fill_q <= fill_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog. Each step's expected y is checked in the same cycle.
// The same value is queued and compared against y_q after the edge.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en = 1'b0, din = 1'b0, cfg_load = 1'b0, cfg_ovl = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;

  logic       y, y_q, cfg_err;
  logic [7:0] match_cnt;
  logic       y2, y_q2, cfg_err2;
  logic [1:0] match_cnt2;

  int  n_pass = 0;
  int  n_chk  = 0;
  bit  exp_q[$];

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y), .y_q(y_q), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y2), .y_q(y_q2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive at negedge, check y, queue it, then check y_q after the edge.
  task automatic cycle(input string tag, input bit ld, input bit clr, input bit e, input bit d,
                       input bit exp_y);
    bit exp_yq;
    @(negedge clk);
    cfg_load = ld; cnt_clr = clr; en = e; din = d;
    #1;
    check({tag, " y"}, y, exp_y);
    exp_q.push_back(exp_y);
    @(posedge clk);
    #1;
    exp_yq = exp_q.pop_front();
    check({tag, " y_q"}, y_q, exp_yq);
    cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  // Load a config with en=1/din=1 present; the load must suppress y.
  task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l, input bit o);
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    cycle({tag, " load"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Scramble the inputs so only the latched copy can matter.
    cfg_pat = ~p; cfg_len = 4'hF; cfg_ovl = ~o;
  endtask

  // Feed n bits (MSB first) with en=1 and the matching expected-y vector.
  task automatic stream(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp_y);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(tag, 1'b0, 1'b0, 1'b1, bits[i], exp_y[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    en = 1'b1; din = 1'b1;
    #2;
    check("reset y", y, 0);
    check("reset y_q", y_q, 0);
    check("reset cnt", match_cnt, 0);
    check("reset cfg_err", cfg_err, 0);
    @(negedge clk);
    en = 1'b0; din = 1'b0;
    rst_n = 1'b1;

    // T1: default 1101, overlap.
    stream("T1", 7, 16'b1101101, 16'b0001001);
    check("T1 cnt", match_cnt, 2);
    check("T1 cnt2", match_cnt2, 2);

    // T2: 1101 non-overlap.
    load("T2", 8'h0D, 4'd4, 1'b0);
    stream("T2", 7, 16'b1101101, 16'b0001000);
    check("T2 cnt", match_cnt, 3);

    // T3: 111, overlap then non-overlap.
    load("T3o", 8'h07, 4'd3, 1'b1);
    stream("T3o", 5, 16'b11111, 16'b00111);
    check("T3o cnt", match_cnt, 6);
    load("T3n", 8'h07, 4'd3, 1'b0);
    stream("T3n", 5, 16'b11111, 16'b00100);
    check("T3n cnt", match_cnt, 7);

    // T4: invalid lengths, then a valid reload whose fill starts over.
    load("T4a", 8'h01, 4'd0, 1'b1);
    check("T4a cfg_err", cfg_err, 1);
    stream("T4a", 5, 16'b11111, 16'b00000);
    load("T4b", 8'h01, 4'd9, 1'b1);
    check("T4b cfg_err", cfg_err, 1);
    stream("T4b", 3, 16'b111, 16'b000);
    // 0101: after three bits {0,1,0,1} already equals the pattern; fill must block it.
    load("T4c", 8'h05, 4'd4, 1'b1);
    check("T4c cfg_err", cfg_err, 0);
    stream("T4c", 5, 16'b10101, 16'b00001);
    check("T4 cnt", match_cnt, 8);

    // T5: clear, len=1 matches every '1'; 2-bit counter saturates; clear wins over match.
    cycle("T5 clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("T5 clr cnt", match_cnt, 0);
    check("T5 clr cnt2", match_cnt2, 0);
    load("T5", 8'h01, 4'd1, 1'b1);
    stream("T5", 6, 16'b111110, 16'b111110);
    check("T5 cnt", match_cnt, 5);
    check("T5 cnt2 sat", match_cnt2, 3);
    cycle("T5 clr+match", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("T5 clr+match cnt", match_cnt, 0);
    check("T5 clr+match cnt2", match_cnt2, 0);

    // T6: en gaps inside 1101.
    load("T6", 8'h0D, 4'd4, 1'b1);
    cycle("T6 b0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("T6 b1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("T6 g0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("T6 g1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("T6 g2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("T6 b2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("T6 b3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("T6 cnt", match_cnt, 1);

    // Async reset between edges right after a match: y_q and count clear at once.
    @(negedge clk);
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("T6 rst y", y, 0);
    check("T6 rst y_q", y_q, 0);
    check("T6 rst cnt", match_cnt, 0);
    #1 rst_n = 1'b1;
    // Without the reset the overlap history would complete 1101 on these three bits.
    stream("T6 post", 3, 16'b101, 16'b000);
    check("T6 post cnt", match_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
